// File: rtl/scc_pkg.sv
// Shared widths, FSM encoding and per-channel state payload for the SCC channel scheduler.
package scc_pkg;

  localparam int unsigned FREQ_W      = 12;
  localparam int unsigned WAVE_ADDR_W = 5;
  localparam int unsigned SAMPLE_W    = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  typedef struct packed {
    logic [FREQ_W-1:0]      cnt;
    logic [WAVE_ADDR_W-1:0] wave;
  } chan_state_t;

endpackage

// File: rtl/scc_channel_state_bank.sv
// Per-channel frequency register, counter and wave address with generator write-back and CPU write.
// SCC_FREQ_WRITE_RESET_EN: a CPU frequency write also clears that channel's counter and wave address.
module scc_channel_state_bank
  import scc_pkg::*;
#(
  parameter int unsigned CHANNELS = 5,
  parameter int unsigned CH_W     = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [CH_W-1:0]        rd_ch,
  output logic [FREQ_W-1:0]      rd_freq,
  output logic [FREQ_W-1:0]      rd_cnt,
  output logic [WAVE_ADDR_W-1:0] rd_wave,
  input  logic                   wb_en,
  input  logic [CH_W-1:0]        wb_ch,
  input  logic [FREQ_W-1:0]      wb_cnt,
  input  logic [WAVE_ADDR_W-1:0] wb_wave,
  input  logic                   cpu_we,
  input  logic [CH_W-1:0]        cpu_ch,
  input  logic [FREQ_W-1:0]      cpu_freq
);

  localparam int unsigned DEPTH = 1 << CH_W;

  chan_state_t       st_q   [DEPTH];
  logic [FREQ_W-1:0] freq_q [DEPTH];
  logic              cpu_hit;

  // Writes to channels beyond CHANNELS are dropped; the extra entries stay at reset.
  assign cpu_hit = cpu_we && ({1'b0, cpu_ch} < (CH_W+1)'(CHANNELS));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        st_q[i]   <= '0;
        freq_q[i] <= '0;
      end
    end else begin
      if (cpu_hit) freq_q[cpu_ch] <= cpu_freq;
      if (wb_en) st_q[wb_ch] <= '{cnt: wb_cnt, wave: wb_wave};
`ifdef SCC_FREQ_WRITE_RESET_EN
      // Placed after the write-back so the clear wins on a same-channel collision.
      if (cpu_hit) st_q[cpu_ch] <= '0;
`endif
    end
  end

  assign rd_freq = freq_q[rd_ch];
  assign rd_cnt  = st_q[rd_ch].cnt;
  assign rd_wave = st_q[rd_ch].wave;

endmodule

// File: rtl/scc_channel_scheduler.sv
// Time-multiplexes one external tone generator across CHANNELS wave channels, one pass per frame tick.
// Optional SCC_FREQ_WRITE_RESET_EN (in the state bank): frequency writes restart the channel.
module scc_channel_scheduler
  import scc_pkg::*;
#(
  parameter int unsigned CHANNELS = 5,
  parameter int unsigned CH_W     = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clk_en,
  input  logic                   reg_we,
  input  logic [CH_W-1:0]        reg_ch,
  input  logic [FREQ_W-1:0]      reg_freq,
  input  logic [CHANNELS-1:0]    key_on,
  output logic [WAVE_ADDR_W-1:0] tg_wave_address_in,
  output logic [FREQ_W-1:0]      tg_frequency_count_in,
  output logic [FREQ_W-1:0]      tg_reg_frequency_count,
  input  logic [WAVE_ADDR_W-1:0] tg_wave_address_out,
  input  logic [FREQ_W-1:0]      tg_frequency_count_out,
  output logic                   mem_req,
  output logic [CH_W+4:0]        mem_addr,
  input  logic                   mem_ack,
  input  logic [SAMPLE_W-1:0]    mem_rdata,
  output logic                   sample_valid,
  output logic [CH_W-1:0]        sample_ch,
  output logic [SAMPLE_W-1:0]    sample_data,
  output logic                   frame_end,
  output logic                   busy,
  output logic                   overrun
);

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(CHANNELS - 1);

  state_t              state, state_nxt;
  logic [CH_W-1:0]     ch, ch_nxt;
  logic [SAMPLE_W-1:0] rdata_q, rdata_nxt;
  logic                wb_en;

  scc_channel_state_bank #(
    .CHANNELS(CHANNELS),
    .CH_W    (CH_W)
  ) u_bank (
    .clk     (clk),
    .reset   (reset),
    .rd_ch   (ch),
    .rd_freq (tg_reg_frequency_count),
    .rd_cnt  (tg_frequency_count_in),
    .rd_wave (tg_wave_address_in),
    .wb_en   (wb_en),
    .wb_ch   (ch),
    .wb_cnt  (tg_frequency_count_out),
    .wb_wave (tg_wave_address_out),
    .cpu_we  (reg_we),
    .cpu_ch  (reg_ch),
    .cpu_freq(reg_freq)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      ch      <= '0;
      rdata_q <= '0;
      overrun <= 1'b0;
    end else begin
      state   <= state_nxt;
      ch      <= ch_nxt;
      rdata_q <= rdata_nxt;
      // A tick arriving during any pass (including its last commit) is dropped and flagged.
      overrun <= clk_en && (state != ST_IDLE);
    end
  end

  always_comb begin
    state_nxt    = state;
    ch_nxt       = ch;
    rdata_nxt    = rdata_q;
    wb_en        = 1'b0;
    mem_req      = 1'b0;
    busy         = 1'b1;
    sample_valid = 1'b0;
    frame_end    = 1'b0;
    sample_data  = '0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (clk_en) begin
          ch_nxt    = '0;
          state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          rdata_nxt = mem_rdata;
          state_nxt = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        wb_en        = 1'b1;
        sample_valid = 1'b1;
        sample_data  = key_on[ch] ? rdata_q : '0;
        if (ch == LAST_CH) begin
          frame_end = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          ch_nxt    = ch + CH_W'(1);
          state_nxt = ST_REQ;
        end
      end
      default: begin
        busy      = 1'b0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign mem_addr  = {ch, tg_wave_address_in};
  assign sample_ch = ch;

endmodule

// File: tb/tb_scc_channel_scheduler.sv
// Directed bench for scc_channel_scheduler with a behavioural tone generator and wave RAM responder.
module tb_scc_channel_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_en;
  logic        reg_we;
  logic [2:0]  reg_ch;
  logic [11:0] reg_freq;
  logic [4:0]  key_on;
  logic [4:0]  tg_wave_address_in;
  logic [11:0] tg_frequency_count_in;
  logic [11:0] tg_reg_frequency_count;
  logic [4:0]  tg_wave_address_out;
  logic [11:0] tg_frequency_count_out;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        sample_valid;
  logic [2:0]  sample_ch;
  logic [7:0]  sample_data;
  logic        frame_end;
  logic        busy;
  logic        overrun;

  int total = 0;
  int bad   = 0;

  // Per-pass observations
  logic [11:0] r_cnt  [8];
  logic [4:0]  r_wave [8];
  logic [11:0] r_freq [8];
  logic [7:0]  r_addr [8];
  logic [7:0]  r_data [8];
  int          r_reqcyc [8];
  int          nsamp, n_ovr, fe_cycle, busy_tail;
  bit          order_ok, addr_ok, pass_done;
  logic [7:0]  rdata_v;

  scc_channel_scheduler #(.CHANNELS(5), .CH_W(3)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .clk_en                (clk_en),
    .reg_we                (reg_we),
    .reg_ch                (reg_ch),
    .reg_freq              (reg_freq),
    .key_on                (key_on),
    .tg_wave_address_in    (tg_wave_address_in),
    .tg_frequency_count_in (tg_frequency_count_in),
    .tg_reg_frequency_count(tg_reg_frequency_count),
    .tg_wave_address_out   (tg_wave_address_out),
    .tg_frequency_count_out(tg_frequency_count_out),
    .mem_req               (mem_req),
    .mem_addr              (mem_addr),
    .mem_ack               (mem_ack),
    .mem_rdata             (mem_rdata),
    .sample_valid          (sample_valid),
    .sample_ch             (sample_ch),
    .sample_data           (sample_data),
    .frame_end             (frame_end),
    .busy                  (busy),
    .overrun               (overrun)
  );

  always #5 clk = ~clk;

  // Tone generator: counter runs 0..freq, wave address advances on each counter wrap.
  always_comb begin
    tg_wave_address_out    = tg_wave_address_in;
    tg_frequency_count_out = tg_frequency_count_in + 12'd1;
    if (tg_frequency_count_in == tg_reg_frequency_count) begin
      tg_frequency_count_out = 12'd0;
      tg_wave_address_out    = tg_wave_address_in + 5'd1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic write_freq(input logic [2:0] c, input logic [11:0] f);
    @(negedge clk);
    reg_we = 1'b1; reg_ch = c; reg_freq = f;
    @(negedge clk);
    reg_we = 1'b0;
  endtask

  // One frame: cycle 1 is the first cycle after the clk_en edge; runs 4 cycles past frame_end.
  task automatic run_pass(input int wait_ch, input int wait_n, input int clken_at,
                          input int wr_at, input logic [2:0] wr_ch, input logic [11:0] wr_val);
    int cyc, waited, trail;
    logic [2:0] c;
    nsamp = 0; n_ovr = 0; fe_cycle = -1; busy_tail = 0;
    order_ok = 1'b1; addr_ok = 1'b1; pass_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      r_reqcyc[i] = 0; r_data[i] = 8'hEE;
    end
    @(negedge clk); clk_en = 1'b1;
    @(negedge clk); clk_en = 1'b0;
    cyc = 1; waited = 0; trail = 0;
    while (!pass_done && cyc < 200) begin
      clk_en   = (cyc == clken_at);
      reg_we   = (cyc == wr_at);
      reg_ch   = wr_ch;
      reg_freq = wr_val;
      mem_ack  = 1'b0;
      mem_rdata = 8'h55;
      if (overrun) n_ovr++;
      if (fe_cycle >= 0) begin
        if (busy) busy_tail++;
        if (sample_valid) nsamp++;
        trail++;
        if (trail >= 4) pass_done = 1'b1;
      end else begin
        if (mem_req) begin
          c = mem_addr[7:5];
          if (r_reqcyc[c] == 0) begin
            r_cnt[c] = tg_frequency_count_in; r_wave[c] = tg_wave_address_in;
            r_freq[c] = tg_reg_frequency_count; r_addr[c] = mem_addr;
          end else if (mem_addr !== r_addr[c]) addr_ok = 1'b0;
          r_reqcyc[c]++;
          if (int'(c) == wait_ch && waited < wait_n) waited++;
          else begin
            mem_ack = 1'b1; mem_rdata = rdata_v;
          end
        end
        if (sample_valid) begin
          if (int'(sample_ch) != nsamp) order_ok = 1'b0;
          r_data[sample_ch] = sample_data;
          nsamp++;
          if (frame_end) fe_cycle = cyc;
        end
      end
      @(negedge clk);
      cyc++;
    end
    clk_en = 1'b0; reg_we = 1'b0; mem_ack = 1'b0;
    check("pass_done", 32'(pass_done), 32'd1);
  endtask

  initial begin
    reset = 1'b1; clk_en = 1'b0; reg_we = 1'b0; reg_ch = '0; reg_freq = '0;
    key_on = 5'b11111; mem_ack = 1'b0; mem_rdata = '0; rdata_v = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_sample_valid", 32'(sample_valid), 32'd0);
    check("rst_frame_end", 32'(frame_end), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_sample_ch", 32'(sample_ch), 32'd0);
    check("rst_sample_data", 32'(sample_data), 32'd0);
    check("rst_tg_cnt", 32'(tg_frequency_count_in), 32'd0);
    check("rst_tg_wave", 32'(tg_wave_address_in), 32'd0);
    check("rst_tg_freq", 32'(tg_reg_frequency_count), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Pass 1: all-zero state, zero-wait ack
    rdata_v = 8'h3C;
    run_pass(-1, 0, -1, -1, 3'd0, 12'd0);
    check("p1_nsamp", 32'(nsamp), 32'd5);
    check("p1_order", 32'(order_ok), 32'd1);
    check("p1_frame_end_cycle", 32'(fe_cycle), 32'd10);
    check("p1_overrun", 32'(n_ovr), 32'd0);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("p1_wave%0d", i), 32'(r_wave[i]), 32'd0);
      check($sformatf("p1_data%0d", i), 32'(r_data[i]), 32'h3C);
    end

    // freq[2]=3; writes to channels 5 and 6 must be dropped
    write_freq(3'd2, 12'd3);
    write_freq(3'd6, 12'd9);
    write_freq(3'd5, 12'd4);

    // Pass 2: every wave address advanced to 1; key_on masks odd channels
    key_on = 5'b10101; rdata_v = 8'h7F;
    run_pass(-1, 0, -1, -1, 3'd0, 12'd0);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("p2_wave%0d", i), 32'(r_wave[i]), 32'd1);
      check($sformatf("p2_cnt%0d", i), 32'(r_cnt[i]), 32'd0);
      check($sformatf("p2_freq%0d", i), 32'(r_freq[i]), (i == 2) ? 32'd3 : 32'd0);
      check($sformatf("p2_data%0d", i), 32'(r_data[i]), (i % 2 == 0) ? 32'h7F : 32'h00);
    end

    // Pass 3: ack on ch1 delayed 3 cycles
    key_on = 5'b11111; rdata_v = 8'h11;
    run_pass(1, 3, -1, -1, 3'd0, 12'd0);
    check("p3_ch1_req_cycles", 32'(r_reqcyc[1]), 32'd4);
    check("p3_ch1_addr", 32'(r_addr[1]), 32'h22);
    check("p3_addr_stable", 32'(addr_ok), 32'd1);
    check("p3_order", 32'(order_ok), 32'd1);
    check("p3_frame_end_cycle", 32'(fe_cycle), 32'd13);
    check("p3_cnt2", 32'(r_cnt[2]), 32'd1);
    check("p3_wave2", 32'(r_wave[2]), 32'd1);
    check("p3_wave1", 32'(r_wave[1]), 32'd2);
    check("p3_data1", 32'(r_data[1]), 32'h11);

    // Pass 4: tick mid-pass
    run_pass(-1, 0, 4, -1, 3'd0, 12'd0);
    check("p4_cnt2", 32'(r_cnt[2]), 32'd2);
    check("p4_overrun", 32'(n_ovr), 32'd1);
    check("p4_nsamp", 32'(nsamp), 32'd5);
    check("p4_frame_end_cycle", 32'(fe_cycle), 32'd10);
    check("p4_busy_tail", 32'(busy_tail), 32'd0);

    // Pass 5: tick coincides with the last commit
    run_pass(-1, 0, 10, -1, 3'd0, 12'd0);
    check("p5_cnt2", 32'(r_cnt[2]), 32'd3);
    check("p5_wave2", 32'(r_wave[2]), 32'd1);
    check("p5_overrun", 32'(n_ovr), 32'd1);
    check("p5_nsamp", 32'(nsamp), 32'd5);
    check("p5_busy_tail", 32'(busy_tail), 32'd0);

    // Pass 6: counter[2] wrapped; frequency write to ch0 during its commit
    run_pass(-1, 0, -1, 2, 3'd0, 12'd7);
    check("p6_cnt2", 32'(r_cnt[2]), 32'd0);
    check("p6_wave2", 32'(r_wave[2]), 32'd2);
    check("p6_wave0", 32'(r_wave[0]), 32'd5);
    check("p6_nsamp", 32'(nsamp), 32'd5);

    // Pass 7: ch0 write-back kept or cleared depending on build
    run_pass(-1, 0, -1, -1, 3'd0, 12'd0);
    check("p7_freq0", 32'(r_freq[0]), 32'd7);
    check("p7_cnt0", 32'(r_cnt[0]), 32'd0);
`ifdef SCC_FREQ_WRITE_RESET_EN
    check("p7_wave0", 32'(r_wave[0]), 32'd0);
`else
    check("p7_wave0", 32'(r_wave[0]), 32'd6);
`endif
    check("p7_wave1", 32'(r_wave[1]), 32'd6);
    check("p7_cnt2", 32'(r_cnt[2]), 32'd1);

    // Reset while ch0 request is outstanding
    @(negedge clk); clk_en = 1'b1;
    @(negedge clk); clk_en = 1'b0;
    check("mid_mem_req", 32'(mem_req), 32'd1);
    check("mid_tg_cnt", 32'(tg_frequency_count_in), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("mid_rst_mem_req", 32'(mem_req), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_tg_cnt", 32'(tg_frequency_count_in), 32'd0);
    check("mid_rst_tg_freq", 32'(tg_reg_frequency_count), 32'd0);
    @(negedge clk); reset = 1'b0; mem_ack = 1'b1;
    // Ack while idle is ignored
    repeat (3) @(negedge clk);
    check("idle_ack_busy", 32'(busy), 32'd0);
    check("idle_ack_sample_valid", 32'(sample_valid), 32'd0);
    mem_ack = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/scc_channel_scheduler.md
Name: scc_channel_scheduler

Overview:
- Time-multiplexes one shared scc_tone_generator datapath across CHANNELS wave channels.
- Holds per-channel state: frequency register, frequency counter and wave address.
- Once per frame tick, steps every channel in order: fetches each channel's wave sample from wave memory via req/ack, then writes back the generator's next state.
- Sits between the CPU register interface, the wave RAM and the mixer.

Parameters:
- CHANNELS, 5, number of channels sequenced per frame (1..8).
- CH_W, 3, channel index width; must satisfy 2**CH_W >= CHANNELS.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- clk_en  in  1  frame tick; starts one scheduling pass
- reg_we  in  1  frequency register write strobe
- reg_ch  in  CH_W  channel written
- reg_freq  in  12  frequency value written
- key_on  in  CHANNELS  per-channel output enable
- tg_wave_address_in  out  5  stored wave address of the current channel, to the generator
- tg_frequency_count_in  out  12  stored counter of the current channel, to the generator
- tg_reg_frequency_count  out  12  frequency register of the current channel, to the generator
- tg_wave_address_out  in  5  next wave address from the generator
- tg_frequency_count_out  in  12  next counter from the generator
- mem_req  out  1  wave RAM read request
- mem_addr  out  CH_W+5  {channel, wave address}
- mem_ack  in  1  read data valid
- mem_rdata  in  8  signed wave sample
- sample_valid  out  1  one-cycle strobe
- sample_ch  out  CH_W  channel of the sample
- sample_data  out  8  sample; 0 when key_on[ch]=0
- frame_end  out  1  one-cycle strobe after the last channel commits
- busy  out  1  pass in progress
- overrun  out  1  one-cycle pulse when clk_en arrives while busy

Behaviour:
- Reset: all freq/counter/wave-address registers 0; state IDLE; ch=0. sample_valid, frame_end, overrun, mem_req and busy = 0; sample_ch=0; sample_data=0.
- FSM states: IDLE, REQ, COMMIT.
- IDLE:
  - busy=0.
  - On clk_en: ch←0, go to REQ.
- REQ:
  - busy=1, mem_req=1, mem_addr={ch, wave_addr[ch]}.
  - tg_* outputs driven from channel ch's stored state.
  - mem_req is held until mem_ack. mem_ack is sampled only in REQ; an ack outside REQ is ignored.
  - On mem_ack: latch mem_rdata, go to COMMIT.
- COMMIT:
  - Write back counter[ch]←tg_frequency_count_out and wave_addr[ch]←tg_wave_address_out.
  - sample_valid=1 for this cycle, with sample_ch=ch and sample_data = key_on[ch] ? latched data : 0.
  - If ch==CHANNELS-1: frame_end=1 this cycle, go to IDLE.
  - Else: ch←ch+1, go to REQ.
- Latency: a pass takes CHANNELS*(2+ack wait) cycles. With zero-wait ack, CHANNELS=5 gives 10 cycles from the cycle after clk_en to frame_end.
- tg_* outputs are combinational from stored state; they are stable through REQ and COMMIT because no write-back occurs before COMMIT.
- clk_en while busy (state != IDLE): ignored, overrun pulses for 1 cycle, the current pass continues.
- clk_en in the same cycle as the COMMIT of the last channel: ignored with overrun. The next pass starts only from IDLE.
- Register writes:
  - reg_we writes freq[reg_ch] at any time, effective next cycle.
  - A write to the channel in REQ changes tg_reg_frequency_count immediately for the commit.
  - reg_ch >= CHANNELS: write dropped.
- Wrap-around: the counter and wave address wrap naturally (12-bit / 5-bit) through the generator; the scheduler adds no saturation.
- Reset mid-pass: everything returns to reset values; any outstanding mem_req is dropped without waiting for ack.

Optional Feature:
- Macro: SCC_FREQ_WRITE_RESET_EN.
- Defined: a reg_we to channel c also clears counter[c]←0 and wave_addr[c]←0 next cycle. If this coincides with the COMMIT of channel c, the clear wins over the write-back. sample_valid is still issued for that commit.
- Undefined: frequency writes never touch counter or wave address.

Decomposition:
- Shared package scc_pkg:
  - widths: FREQ_W=12, WAVE_ADDR_W=5, SAMPLE_W=8;
  - FSM state enum constants ST_IDLE, ST_REQ, ST_COMMIT.
- One natural sub-module: scc_channel_state_bank, the per-channel register file with a write-back port, a CPU write port and an optional clear.
- The FSM stays in the top.
- The tone generator is external and connected through the tg_* ports.

Test Plan:
- Reset, then clk_en with zero-wait ack, all freq=0 → 5 sample_valid on ch 0..4; every wave_addr becomes 1; frame_end 10 cycles after clk_en.
- freq[2]=3, 4 passes → wave_addr[2]=1 after pass 4 and counter[2]=0; counter[2] reads 1,2,3,0 after passes 1..4.
- mem_ack delayed 3 cycles on ch1 → mem_req held 4 cycles with mem_addr stable {1,addr}; no commit before ack.
- key_on=5'b10101 with mem_rdata=8'h7F → sample_data 7F,00,7F,00,7F for ch 0..4.
- clk_en asserted mid-pass → overrun pulse 1 cycle; exactly 5 samples in the pass; no second pass starts until the next clk_en seen in IDLE.
- With SCC_FREQ_WRITE_RESET_EN: reg_we to ch0 in the cycle of ch0's COMMIT → counter[0]=0, wave_addr[0]=0. Without the macro: write-back values are kept.
